// File: rtl/load_sequencer_pkg.sv
// Shared definitions for the load sequencer slice.
// Contents: per-phase load codes, sequencer state encoding, pattern widths
// and a helper that detects a NUL code anywhere in a packed pattern triple.
package load_sequencer_pkg;

   localparam int CODE_W    = 2;
   localparam int PAT_W     = 3 * CODE_W;   // {A,B,C}
   localparam int CFG_PAT_W = 3 * PAT_W;    // {pat0,pat1,pat2}

   typedef enum logic [CODE_W-1:0] {
      NUL = 2'b00,
      LAA = 2'b01,
      LBB = 2'b10,
      LCC = 2'b11
   } load_code_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARM   = 2'b01,
      ST_RUN   = 2'b10,
      ST_FAULT = 2'b11
   } seq_state_e;

   localparam logic [PAT_W-1:0] PAT_NUL = '0;

   function automatic logic pat_has_nul(input logic [CFG_PAT_W-1:0] pats);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < CFG_PAT_W / CODE_W; i++) begin
         if (pats[i*CODE_W +: CODE_W] == NUL) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/load_cfg_check.sv
// Combinational validator for an offered load schedule.
// Ports:
//   period, seg0, seg1 : offered period and first two segment lengths (cycles)
//   pat                : offered {pat0,pat1,pat2}
//   ok / err           : schedule usable / schedule rejected (err = !ok)
// Segment 2 is the remainder of the period and must also be at least MIN_SEG,
// so the sum is formed two bits wider than the operands to avoid wrap.
module load_cfg_check
   import load_sequencer_pkg::*;
#(
   parameter int PERIOD_W = 12,
   parameter int MIN_SEG  = 8
) (
   input  logic [PERIOD_W-1:0]  period,
   input  logic [PERIOD_W-1:0]  seg0,
   input  logic [PERIOD_W-1:0]  seg1,
   input  logic [CFG_PAT_W-1:0] pat,
   output logic                 ok,
   output logic                 err
);

   localparam logic [PERIOD_W-1:0] MIN_SEG_N = PERIOD_W'(MIN_SEG);
   localparam logic [PERIOD_W+1:0] MIN_SEG_W = (PERIOD_W+2)'(MIN_SEG);

   logic [PERIOD_W+1:0] need;

   assign need = {2'b00, seg0} + {2'b00, seg1} + MIN_SEG_W;
   assign ok   = (seg0 >= MIN_SEG_N) && (seg1 >= MIN_SEG_N) &&
                 ({2'b00, period} >= need) && !pat_has_nul(pat);
   assign err  = !ok;

endmodule

// File: rtl/load_sequencer.sv
// Per-period load pattern sequencer feeding top_commutation.
// Ports:
//   clk, rst (async, active-low)
//   enable            : run request
//   cfg_valid/ready   : one-deep config handshake; cfg_period/seg0/seg1/pat payload
//   short, fault_clr  : commutation short flag / fault acknowledge
//   DesiredLoad       : active pattern (NUL outside RUN)
//   start             : commutation enable
//   period_start      : pulse at count 0 of each period
//   cfg_err           : pulse after a rejected config
//   fault             : high while in FAULT
//
//   state | meaning
//   IDLE  | stopped, output NUL, waiting for enable
//   ARM   | enabled, waiting for a pending schedule
//   RUN   | sequencing pat0/pat1/pat2 over the active period
//   FAULT | short seen, output NUL, waiting for fault_clr with short low
module load_sequencer
   import load_sequencer_pkg::*;
#(
   parameter int PERIOD_W = 12,
   parameter int MIN_SEG  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [PERIOD_W-1:0]  cfg_period,
   input  logic [PERIOD_W-1:0]  cfg_seg0,
   input  logic [PERIOD_W-1:0]  cfg_seg1,
   input  logic [CFG_PAT_W-1:0] cfg_pat,
   input  logic                 short,
   input  logic                 fault_clr,
   output logic [PAT_W-1:0]     DesiredLoad,
   output logic                 start,
   output logic                 period_start,
   output logic                 cfg_err,
   output logic                 fault
);

   seq_state_e state, state_n;
   logic [PERIOD_W-1:0]  cnt, cnt_n;
   logic                 stop_req, stop_n;
   logic                 pending;
   logic [PERIOD_W-1:0]  sh_period, sh_seg0, sh_seg1;
   logic [CFG_PAT_W-1:0] sh_pat;
   logic [PERIOD_W-1:0]  ac_period, ac_seg0, ac_seg1;
   logic [CFG_PAT_W-1:0] ac_pat;
   logic [PAT_W-1:0]     load_q, load_n;
   logic                 start_q, start_n;
   logic                 pstart_q, pstart_n;
   logic                 cfg_err_q;
   logic                 swap, wrap;
   logic                 chk_ok, chk_err;
   logic                 take;
   logic [PERIOD_W-1:0]  src_seg0, src_seg1;
   logic [CFG_PAT_W-1:0] src_pat;
   logic [PERIOD_W:0]    bnd1;

   load_cfg_check #(
      .PERIOD_W (PERIOD_W),
      .MIN_SEG  (MIN_SEG)
   ) u_cfg_check (
      .period (cfg_period),
      .seg0   (cfg_seg0),
      .seg1   (cfg_seg1),
      .pat    (cfg_pat),
      .ok     (chk_ok),
      .err    (chk_err)
   );

   assign cfg_ready    = !pending && (state != ST_FAULT);
   // A transfer coinciding with a short that will trip FAULT is dropped.
   assign take         = cfg_valid && cfg_ready && !(short && state != ST_IDLE);
   assign wrap         = (cnt == ac_period - 1'b1);
   assign DesiredLoad  = load_q;
   assign start        = start_q;
   assign period_start = pstart_q;
   assign cfg_err      = cfg_err_q;
   assign fault        = (state == ST_FAULT);

   // On a swap the next output is drawn from the shadow schedule.
   assign src_seg0 = swap ? sh_seg0 : ac_seg0;
   assign src_seg1 = swap ? sh_seg1 : ac_seg1;
   assign src_pat  = swap ? sh_pat  : ac_pat;
   assign bnd1     = {1'b0, src_seg0} + {1'b0, src_seg1};

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      stop_n   = 1'b0;
      swap     = 1'b0;
      start_n  = 1'b0;
      pstart_n = 1'b0;
      load_n   = PAT_NUL;
      case (state)
         ST_IDLE: begin
            if (enable) state_n = ST_ARM;
         end
         ST_ARM: begin
            if (short) begin
               state_n = ST_FAULT;
            end else if (!enable) begin
               state_n = ST_IDLE;
            end else if (pending) begin
               state_n  = ST_RUN;
               swap     = 1'b1;
               cnt_n    = '0;
               start_n  = 1'b1;
               pstart_n = 1'b1;
            end
         end
         ST_RUN: begin
            if (short) begin
               state_n = ST_FAULT;
            end else if (wrap) begin
               if (stop_req || !enable) begin
                  state_n = ST_IDLE;
               end else begin
                  cnt_n    = '0;
                  swap     = pending;
                  start_n  = 1'b1;
                  pstart_n = 1'b1;
               end
            end else begin
               // Once a stop is requested it sticks until the period ends.
               stop_n  = stop_req || !enable;
               cnt_n   = cnt + 1'b1;
               start_n = 1'b1;
            end
         end
         ST_FAULT: begin
            if (fault_clr && !short) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase

      if (start_n) begin
         if ({1'b0, cnt_n} < {1'b0, src_seg0})
            load_n = src_pat[CFG_PAT_W-1 -: PAT_W];
         else if ({1'b0, cnt_n} < bnd1)
            load_n = src_pat[PAT_W +: PAT_W];
         else
            load_n = src_pat[PAT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         stop_req  <= 1'b0;
         pending   <= 1'b0;
         sh_period <= '0;
         sh_seg0   <= '0;
         sh_seg1   <= '0;
         sh_pat    <= '0;
         ac_period <= '0;
         ac_seg0   <= '0;
         ac_seg1   <= '0;
         ac_pat    <= '0;
         load_q    <= PAT_NUL;
         start_q   <= 1'b0;
         pstart_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         stop_req  <= stop_n;
         load_q    <= load_n;
         start_q   <= start_n;
         pstart_q  <= pstart_n;
         cfg_err_q <= take && chk_err;

         if (state_n == ST_FAULT) begin
            pending <= 1'b0;
         end else if (swap) begin
            pending <= 1'b0;
         end else if (take && chk_ok) begin
            pending   <= 1'b1;
            sh_period <= cfg_period;
            sh_seg0   <= cfg_seg0;
            sh_seg1   <= cfg_seg1;
            sh_pat    <= cfg_pat;
         end

         if (swap) begin
            ac_period <= sh_period;
            ac_seg0   <= sh_seg0;
            ac_seg1   <= sh_seg1;
            ac_pat    <= sh_pat;
         end
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [11:0] cfg_period;
   logic [11:0] cfg_seg0;
   logic [11:0] cfg_seg1;
   logic [17:0] cfg_pat;
   logic        short;
   logic        fault_clr;
   logic [5:0]  DesiredLoad;
   logic        start;
   logic        period_start;
   logic        cfg_err;
   logic        fault;

   int checks   = 0;
   int failures = 0;
   int cnt      = 0;

   localparam logic [5:0] P0  = 6'b011011;
   localparam logic [5:0] P1  = 6'b101101;
   localparam logic [5:0] P2  = 6'b110110;
   localparam logic [5:0] PCC = 6'b111111;

   logic [5:0] e_p0, nxt_p0;

   load_sequencer #(.PERIOD_W(12), .MIN_SEG(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_period   (cfg_period),
      .cfg_seg0     (cfg_seg0),
      .cfg_seg1     (cfg_seg1),
      .cfg_pat      (cfg_pat),
      .short        (short),
      .fault_clr    (fault_clr),
      .DesiredLoad  (DesiredLoad),
      .start        (start),
      .period_start (period_start),
      .cfg_err      (cfg_err),
      .fault        (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] exp_load(input int c);
      if (c < 10)      return e_p0;
      else if (c < 22) return P1;
      else             return P2;
   endfunction

   task automatic check_run();
      chk($sformatf("load_c%0d", cnt), {26'd0, DesiredLoad}, {26'd0, exp_load(cnt)});
      chk($sformatf("start_c%0d", cnt), {31'd0, start}, 32'd1);
      chk($sformatf("pstart_c%0d", cnt), {31'd0, period_start}, (cnt == 0) ? 32'd1 : 32'd0);
   endtask

   task automatic step();
      tick();
      cnt = (cnt + 1) % 40;
      if (cnt == 0) e_p0 = nxt_p0;
      check_run();
   endtask

   task automatic run_until(input int target);
      do step(); while (cnt != target);
   endtask

   task automatic set_cfg(input logic [11:0] p, input logic [11:0] s0,
                          input logic [11:0] s1, input logic [17:0] pt);
      cfg_period = p;
      cfg_seg0   = s0;
      cfg_seg1   = s1;
      cfg_pat    = pt;
   endtask

   initial begin
      rst       = 1'b0;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      short     = 1'b0;
      fault_clr = 1'b0;
      set_cfg(12'd0, 12'd0, 12'd0, 18'd0);
      e_p0      = P0;
      nxt_p0    = P0;
      tick();
      tick();
      chk("rst_load",   {26'd0, DesiredLoad}, 32'd0);
      chk("rst_start",  {31'd0, start}, 32'd0);
      chk("rst_pstart", {31'd0, period_start}, 32'd0);
      chk("rst_cfg_err",{31'd0, cfg_err}, 32'd0);
      chk("rst_fault",  {31'd0, fault}, 32'd0);
      chk("rst_ready",  {31'd0, cfg_ready}, 32'd1);
      rst = 1'b1;
      tick();

      // Basic: load the common schedule, then enable
      set_cfg(12'd40, 12'd10, 12'd12, {P0, P1, P2});
      cfg_valid = 1'b1;
      tick();
      chk("basic_ready_low", {31'd0, cfg_ready}, 32'd0);
      chk("basic_no_err",    {31'd0, cfg_err}, 32'd0);
      cfg_valid = 1'b0;
      enable    = 1'b1;
      tick();
      chk("arm_start", {31'd0, start}, 32'd0);
      chk("arm_load",  {26'd0, DesiredLoad}, 32'd0);
      tick();
      cnt = 0;
      check_run();
      chk("run_ready", {31'd0, cfg_ready}, 32'd1);
      run_until(0);

      // Reload mid-period: new pat0 shows only from the next count 0
      run_until(5);
      set_cfg(12'd40, 12'd10, 12'd12, {PCC, P1, P2});
      cfg_valid = 1'b1;
      step();
      chk("reload_ready_low", {31'd0, cfg_ready}, 32'd0);
      cfg_valid = 1'b0;
      nxt_p0 = PCC;
      run_until(39);
      chk("reload_ready_c39", {31'd0, cfg_ready}, 32'd0);
      step();
      chk("reload_ready_wrap", {31'd0, cfg_ready}, 32'd1);
      run_until(10);

      // Reject: short seg1, then a NUL code
      set_cfg(12'd40, 12'd10, 12'd5, {P0, P1, P2});
      cfg_valid = 1'b1;
      step();
      chk("rej_seg_err", {31'd0, cfg_err}, 32'd1);
      set_cfg(12'd40, 12'd10, 12'd12, {P0, P1, 6'b110100});
      step();
      chk("rej_nul_err", {31'd0, cfg_err}, 32'd1);
      cfg_valid = 1'b0;
      step();
      chk("rej_err_clear", {31'd0, cfg_err}, 32'd0);
      chk("rej_ready",     {31'd0, cfg_ready}, 32'd1);
      run_until(0);

      // Short at count 15; concurrent config offer must be dropped
      run_until(15);
      short = 1'b1;
      set_cfg(12'd40, 12'd10, 12'd12, {P0, P1, P2});
      cfg_valid = 1'b1;
      tick();
      chk("short_load",  {26'd0, DesiredLoad}, 32'd0);
      chk("short_start", {31'd0, start}, 32'd0);
      chk("short_fault", {31'd0, fault}, 32'd1);
      chk("short_err",   {31'd0, cfg_err}, 32'd0);
      chk("short_ready", {31'd0, cfg_ready}, 32'd0);
      cfg_valid = 1'b0;
      fault_clr = 1'b1;
      tick();
      chk("clr_held_fault", {31'd0, fault}, 32'd1);
      short = 1'b0;
      tick();
      chk("clr_fault", {31'd0, fault}, 32'd0);
      chk("clr_load",  {26'd0, DesiredLoad}, 32'd0);
      chk("clr_ready", {31'd0, cfg_ready}, 32'd1);
      fault_clr = 1'b0;
      enable    = 1'b1;
      tick();
      tick();
      chk("no_pending_arm1", {31'd0, start}, 32'd0);
      tick();
      chk("no_pending_arm2", {31'd0, start}, 32'd0);
      enable = 1'b0;
      tick();

      // Stop: enable drops at 20, returns at 30; period still completes to IDLE
      nxt_p0 = P0;
      e_p0   = P0;
      set_cfg(12'd40, 12'd10, 12'd12, {P0, P1, P2});
      cfg_valid = 1'b1;
      enable    = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      cnt = 0;
      check_run();
      run_until(20);
      enable = 1'b0;
      run_until(30);
      enable = 1'b1;
      run_until(39);
      tick();
      chk("stop_start",  {31'd0, start}, 32'd0);
      chk("stop_load",   {26'd0, DesiredLoad}, 32'd0);
      chk("stop_pstart", {31'd0, period_start}, 32'd0);
      tick();
      chk("rearm_start", {31'd0, start}, 32'd0);

      // Reset mid-run at count 30
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      cnt = 0;
      check_run();
      run_until(30);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_load",   {26'd0, DesiredLoad}, 32'd0);
      chk("arst_start",  {31'd0, start}, 32'd0);
      chk("arst_pstart", {31'd0, period_start}, 32'd0);
      chk("arst_fault",  {31'd0, fault}, 32'd0);
      enable = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
      chk("post_rst_start", {31'd0, start}, 32'd0);
      chk("post_rst_load",  {26'd0, DesiredLoad}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
